// File: rtl/skinny_round_ctrl_if.sv
// rtl/skinny_round_ctrl_if.sv - start request and state-register control bundle of the SKINNY round controller
interface skinny_round_ctrl_if;
  logic       start;
  logic       sel;
  logic       state_en;
  logic       pipe_en;
  logic [5:0] rc;
  logic [5:0] round;
  logic       busy;
  logic       done;

  modport master (
    output start,
    input  sel, state_en, pipe_en, rc, round, busy, done
  );

  modport slave (
    input  start,
    output sel, state_en, pipe_en, rc, round, busy, done
  );
endinterface

// File: rtl/skinny_round_ctrl.sv
// rtl/skinny_round_ctrl.sv - load/round sequencer, round index and 6-bit round-constant LFSR for the pipelined masked SKINNY core
module skinny_round_ctrl #(
  parameter int NUM_ROUNDS = 40,
  parameter int STAGES     = 4
) (
  input  logic               clk,
  input  logic               rst,
  skinny_round_ctrl_if.slave bus
);

  localparam int              SW         = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [SW-1:0]   STG_LAST   = SW'(STAGES - 1);
  localparam logic [5:0]      ROUND_LAST = 6'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state, state_d;
  logic [SW-1:0] stg, stg_d;
  logic [5:0]    round_q, round_d;
  logic [5:0]    rc_q, rc_d;
  logic          stg_last;

  logic sel_o, state_en_o, pipe_en_o, busy_o, done_o;

  assign stg_last = (stg == STG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      stg     <= '0;
      round_q <= '0;
      rc_q    <= '0;
    end else begin
      state   <= state_d;
      stg     <= stg_d;
      round_q <= round_d;
      rc_q    <= rc_d;
    end
  end

  always_comb begin
    state_d    = state;
    stg_d      = stg;
    round_d    = round_q;
    rc_d       = rc_q;
    sel_o      = 1'b1;
    state_en_o = 1'b0;
    pipe_en_o  = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        sel_o      = 1'b0;
        state_en_o = 1'b1;
        busy_o     = 1'b1;
        state_d    = RUN;
        stg_d      = '0;
        round_d    = 6'd1;
        rc_d       = 6'h01;
      end
      RUN: begin
        pipe_en_o  = 1'b1;
        busy_o     = 1'b1;
        state_en_o = stg_last;
        if (stg_last) begin
          stg_d = '0;
          // Last round: index and constant stay visible through DONE.
          if (round_q == ROUND_LAST) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 6'd1;
            rc_d    = {rc_q[4:0], ~(rc_q[5] ^ rc_q[4])};
          end
        end else begin
          stg_d = stg + 1'b1;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        busy_o  = 1'b1;
        state_d = IDLE;
        round_d = '0;
        rc_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sel      = sel_o;
  assign bus.state_en = state_en_o;
  assign bus.pipe_en  = pipe_en_o;
  assign bus.busy     = busy_o;
  assign bus.done     = done_o;
  assign bus.round    = round_q;
  assign bus.rc       = rc_q;

endmodule
